// File: rtl/squash_ctrl.sv
// squash_ctrl: turns branch/jump invalidation counts into per-stage valid bits,
// with an exception kill and a saturating squashed-fetch counter.
module squash_ctrl #(
    parameter int NSTAGE = 5,
    parameter int CW     = 3,
    parameter int KDEPTH = 3,
    parameter int SCW    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              kill,
    input  logic [CW-1:0]     inv_req,
    input  logic              fetch_vld,
    output logic [NSTAGE-1:0] stage_vld,
    output logic              squash,
    output logic [CW-1:0]     remain,
    output logic              busy,
    output logic [SCW-1:0]    sq_count
);
    localparam logic [NSTAGE-1:0] KMASK = {NSTAGE{1'b1}} << KDEPTH;
    logic [CW-1:0]     r_cnt;
    logic [NSTAGE-1:0] r_vld;
    logic [SCW-1:0]    r_sq;
    logic [CW-1:0]     w_eff;
    logic              w_nz;
    logic              w_in;
    logic [NSTAGE-1:0] w_shift;
    logic [CW-1:0]     w_next;
    // Requests merge by max so a late short request never truncates a pending one
    assign w_eff   = (r_cnt > inv_req) ? r_cnt : inv_req;
    assign w_nz    = w_eff != '0;
    assign w_in    = fetch_vld && !w_nz;
    assign w_shift = {r_vld[NSTAGE-2:0], w_in};
    assign w_next  = squash ? w_eff - CW'(1) : (fetch_vld ? '0 : w_eff);
    assign squash  = !kill && !stall && fetch_vld && w_nz;
    assign busy    = r_cnt != '0;
    assign remain  = r_cnt;
    assign stage_vld = r_vld;
    assign sq_count  = r_sq;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_vld <= '0;
            r_sq  <= '0;
        end else if (kill) begin
            r_cnt <= '0;
            r_vld <= (stall ? r_vld : w_shift) & KMASK;
        end else if (stall) begin
            r_cnt <= w_eff;
        end else begin
            r_cnt <= w_next;
            r_vld <= w_shift;
            if (squash && r_sq != '1)
                r_sq <= r_sq + SCW'(1);
        end
    end
endmodule

// File: tb/tb_squash_ctrl.sv
// tb_squash_ctrl: directed vector table plus randomized run against a
// behavioural model; a narrow-counter instance exercises saturation.
module tb_squash_ctrl;
    localparam int NS = 5;
    localparam int KD = 3;
    logic       clk = 1'b0;
    logic       reset, stall, kill, fetch_vld;
    logic [2:0] inv_req;
    logic [4:0] stage_vld, s_vld;
    logic       squash, busy, s_squash, s_busy;
    logic [2:0] remain, s_remain;
    logic [15:0] sq_count;
    logic [3:0]  s_sq;
    int tests = 0;
    int fails = 0;
    int m_cnt = 0;
    int m_tot = 0;
    int m_vld[NS] = '{default: 0};

    squash_ctrl #(.NSTAGE(NS), .CW(3), .KDEPTH(KD), .SCW(16)) u_dut (
        .clk(clk), .reset(reset), .stall(stall), .kill(kill), .inv_req(inv_req),
        .fetch_vld(fetch_vld), .stage_vld(stage_vld), .squash(squash),
        .remain(remain), .busy(busy), .sq_count(sq_count));

    squash_ctrl #(.NSTAGE(NS), .CW(3), .KDEPTH(KD), .SCW(4)) u_sat (
        .clk(clk), .reset(reset), .stall(stall), .kill(kill), .inv_req(inv_req),
        .fetch_vld(fetch_vld), .stage_vld(s_vld), .squash(s_squash),
        .remain(s_remain), .busy(s_busy), .sq_count(s_sq));

    always #5 clk = ~clk;

    typedef struct {
        bit r, s, k;
        bit [2:0] inv;
        bit f;
        bit sq;
        int rem;
        bit [4:0] vld;
        int cnt;
    } vec_t;
    vec_t tab[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] mpack();
        logic [4:0] v;
        for (int i = 0; i < NS; i++) v[i] = m_vld[i][0];
        return v;
    endfunction

    task automatic step(input bit r, s, k, input bit [2:0] inv, input bit f,
                        input bit mchk, output logic o_sq);
        int eff;
        int ncnt;
        int nv[NS];
        bit e_sq;
        reset = r; stall = s; kill = k; inv_req = inv; fetch_vld = f;
        eff  = (m_cnt > int'(inv)) ? m_cnt : int'(inv);
        e_sq = !k && !s && f && eff != 0;
        nv   = m_vld;
        ncnt = m_cnt;
        if (r) begin
            ncnt = 0; m_tot = 0;
            for (int i = 0; i < NS; i++) nv[i] = 0;
        end else if (k) begin
            ncnt = 0;
            for (int i = 0; i < NS; i++)
                if (i < KD) nv[i] = 0;
                else if (!s) nv[i] = m_vld[i-1];
        end else if (s) begin
            ncnt = eff;
        end else begin
            for (int i = 1; i < NS; i++) nv[i] = m_vld[i-1];
            nv[0] = (f && eff == 0) ? 1 : 0;
            ncnt  = !f ? eff : (eff != 0 ? eff - 1 : 0);
            if (e_sq) m_tot++;
        end
        #2;
        o_sq = squash;
        if (mchk) begin
            chk("squash", 32'(squash), 32'(e_sq));
            chk("busy", 32'(busy), 32'(m_cnt != 0));
        end
        @(posedge clk);
        m_cnt = ncnt;
        m_vld = nv;
        #1;
        if (mchk) begin
            chk("remain", 32'(remain), 32'(m_cnt));
            chk("stage_vld", 32'(stage_vld), 32'(mpack()));
            chk("sq_count", 32'(sq_count), 32'((m_tot > 65535) ? 65535 : m_tot));
            chk("sq_count_sat4", 32'(s_sq), 32'((m_tot > 15) ? 15 : m_tot));
        end
    endtask

    initial begin
        logic o;
        reset = 1'b1; stall = 1'b0; kill = 1'b0; inv_req = 3'd0; fetch_vld = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rst_remain", 32'(remain), 0);
        chk("rst_vld", 32'(stage_vld), 0);
        chk("rst_sq_count", 32'(sq_count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_squash", 32'(squash), 0);
        @(posedge clk); #1;
        // the cycle above passed one valid fetch; clear it so the table starts empty
        step(1, 0, 0, 3'd0, 0, 0, o);
        //              r  s  k  inv f  sq rem vld        cnt
        tab.push_back('{0, 0, 0, 3, 1, 1, 2, 5'b00000, 1});
        tab.push_back('{0, 0, 0, 0, 1, 1, 1, 5'b00000, 2});
        tab.push_back('{0, 0, 0, 0, 1, 1, 0, 5'b00000, 3});
        tab.push_back('{0, 0, 0, 0, 1, 0, 0, 5'b00001, 3});
        tab.push_back('{0, 0, 0, 0, 0, 0, 0, 5'b00010, 3});
        tab.push_back('{0, 0, 0, 4, 1, 1, 3, 5'b00100, 4});
        tab.push_back('{0, 0, 0, 0, 0, 0, 3, 5'b01000, 4});
        tab.push_back('{0, 0, 0, 0, 1, 1, 2, 5'b10000, 5});
        tab.push_back('{0, 0, 0, 0, 1, 1, 1, 5'b00000, 6});
        tab.push_back('{0, 0, 0, 0, 0, 0, 1, 5'b00000, 6});
        tab.push_back('{0, 0, 0, 0, 1, 1, 0, 5'b00000, 7});
        tab.push_back('{0, 0, 0, 0, 1, 0, 0, 5'b00001, 7});
        tab.push_back('{0, 0, 0, 2, 0, 0, 2, 5'b00010, 7});
        tab.push_back('{0, 1, 0, 4, 1, 0, 4, 5'b00010, 7});
        tab.push_back('{0, 1, 0, 0, 1, 0, 4, 5'b00010, 7});
        tab.push_back('{0, 0, 0, 0, 1, 1, 3, 5'b00100, 8});
        tab.push_back('{0, 0, 0, 0, 1, 1, 2, 5'b01000, 9});
        tab.push_back('{0, 0, 0, 0, 1, 1, 1, 5'b10000, 10});
        tab.push_back('{0, 0, 0, 0, 1, 1, 0, 5'b00000, 11});
        tab.push_back('{0, 0, 0, 0, 1, 0, 0, 5'b00001, 11});
        tab.push_back('{0, 0, 0, 0, 1, 0, 0, 5'b00011, 11});
        tab.push_back('{0, 0, 0, 0, 1, 0, 0, 5'b00111, 11});
        tab.push_back('{0, 0, 0, 0, 1, 0, 0, 5'b01111, 11});
        tab.push_back('{0, 0, 0, 0, 1, 0, 0, 5'b11111, 11});
        tab.push_back('{0, 0, 1, 5, 1, 0, 0, 5'b11000, 11});
        tab.push_back('{0, 0, 0, 2, 0, 0, 2, 5'b10000, 11});
        tab.push_back('{0, 1, 1, 0, 1, 0, 0, 5'b10000, 11});
        tab.push_back('{0, 0, 0, 3, 1, 1, 2, 5'b00000, 12});
        tab.push_back('{1, 0, 0, 0, 1, 1, 0, 5'b00000, 0});
        tab.push_back('{0, 0, 0, 0, 1, 0, 0, 5'b00001, 0});
        foreach (tab[i]) begin
            step(tab[i].r, tab[i].s, tab[i].k, tab[i].inv, tab[i].f, 0, o);
            chk($sformatf("vec%0d_squash", i), 32'(o), 32'(tab[i].sq));
            chk($sformatf("vec%0d_remain", i), 32'(remain), 32'(tab[i].rem));
            chk($sformatf("vec%0d_vld", i), 32'(stage_vld), 32'(tab[i].vld));
            chk($sformatf("vec%0d_sq_count", i), 32'(sq_count), 32'(tab[i].cnt));
        end
        // long squash run drives the 4-bit counter into saturation
        for (int i = 0; i < 24; i++) step(0, 0, 0, 3'd7, 1, 1, o);
        chk("sat_hold", 32'(s_sq), 32'd15);
        for (int i = 0; i < 500; i++)
            step(($urandom_range(99) < 2), ($urandom_range(99) < 20), ($urandom_range(99) < 5),
                 ($urandom_range(99) < 25) ? 3'($urandom_range(7, 1)) : 3'd0,
                 ($urandom_range(99) < 70), 1, o);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
